// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive front end.
// Holds the FSM state enum, the data width and the default period clamp.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;
  localparam int unsigned DEF_MIN_BIT_PERIOD = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  function automatic logic [31:0] eff_period(
    input logic [31:0] p,
    input logic [31:0] pmin
  );
    return (p < pmin) ? pmin : p;
  endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// uart_rx_sync_filter: rx_i synchronizer chain plus 3-sample majority vote.
// Ports: clk_i, arst_n_i (async low), rx_i (async line), line_o (filtered).
module uart_rx_sync_filter
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic rx_i,
  output logic line_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_samp;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_sync <= '1;
      r_samp <= 3'b111;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
      r_samp <= {r_samp[1:0], r_sync[SYNC_STAGES-1]};
    end
  end

  assign line_o = (r_samp[0] & r_samp[1]) |
                  (r_samp[0] & r_samp[2]) |
                  (r_samp[1] & r_samp[2]);

endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with valid/ready output and error pulses.
// Ports: clk_i, arst_n_i, rx_i, bit_period_i[31:0], rdata_o[7:0], rvalid_o,
//        rready_i, frame_err_o, overrun_o, busy_o.
module uart_rx_frontend
  import uart_rx_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned MIN_BIT_PERIOD = DEF_MIN_BIT_PERIOD
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 rx_i,
  input  logic [31:0]          bit_period_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  // Cycles after reset until line_o reflects rx_i through every flop.
  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 3);

  rx_state_t              r_state;
  logic [31:0]            r_period;
  logic [31:0]            r_cnt;
  logic [2:0]             r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_prev;
  logic [2:0]             r_warm;

  logic                   w_line;
  logic [31:0]            w_p_eff;
  logic                   w_fall;
  logic                   w_exp;

  uart_rx_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .rx_i    (rx_i),
    .line_o  (w_line)
  );

  assign w_p_eff = eff_period(bit_period_i, 32'(MIN_BIT_PERIOD));
  assign w_fall  = r_prev & ~w_line;
  assign w_exp   = (r_cnt == 32'd1);
  assign busy_o  = (r_state != IDLE);

  // r_prev is held low until the filter is flushed, so a line that is
  // already low at reset release must go high before a start is seen.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_warm <= 3'd0;
      r_prev <= 1'b0;
    end else begin
      if (r_warm != WARM) r_warm <= r_warm + 3'd1;
      r_prev <= (r_warm == WARM) ? w_line : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= IDLE;
      r_period    <= 32'd0;
      r_cnt       <= 32'd0;
      r_idx       <= 3'd0;
      r_shift     <= '0;
      rdata_o     <= '0;
      rvalid_o    <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (rvalid_o && rready_i) rvalid_o <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_period <= w_p_eff;
            r_cnt    <= w_p_eff >> 1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_exp) begin
            if (w_line) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_period;
              r_idx   <= 3'd0;
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        DATA: begin
          if (w_exp) begin
            r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_period;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'(DATA_BITS - 1)) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        STOP: begin
          if (w_exp) begin
            if (w_line) begin
              r_state <= IDLE;
              // A slot freed by this cycle's handshake can take the byte.
              if (!rvalid_o || rready_i) begin
                rdata_o  <= r_shift;
                rvalid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              r_cnt       <= r_period;
              r_state     <= BREAK_WAIT;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        BREAK_WAIT: begin
          if (!w_line) begin
            r_cnt <= r_period;
          end else if (w_exp) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames checked against a frame-level model.
// Model predicts each frame outcome at start + 9P + P/2 + SYNC + 3 cycles.
module tb_uart_rx_frontend;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        rx = 1'b1;
  logic        rready = 1'b0;
  logic [31:0] bit_period = 32'd868;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .rx_i        (rx),
    .bit_period_i(bit_period),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  typedef struct {
    int       edge_n;
    logic [7:0] d;
    bit       good;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         rv_rise = -1;
  logic       prev_rv = 1'b0;
  logic       m_v = 1'b0;
  logic [7:0] m_d = 8'h00;
  logic       m_fe;
  logic       m_ov;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame-level model: outputs after each rising edge, checked 1 unit later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!arst_n) begin
        m_v = 1'b0;
        m_d = 8'h00;
        prev_rv = 1'b0;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
      end else begin
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (evq.size() > 0 && evq[0].edge_n == cyc) begin
          ev = evq.pop_front();
          if (ev.good) begin
            if (!m_v || rready) begin
              m_v = 1'b1;
              m_d = ev.d;
            end else begin
              m_ov = 1'b1;
            end
          end else begin
            m_fe = 1'b1;
            if (m_v && rready) m_v = 1'b0;
          end
        end else if (m_v && rready) begin
          m_v = 1'b0;
        end
        chk("rvalid", rvalid, m_v);
        chk("rdata", rdata, m_d);
        chk("frame_err", frame_err, m_fe);
        chk("overrun", overrun, m_ov);
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
        if (rvalid && !prev_rv) rv_rise = cyc;
        prev_rv = rvalid;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int p, input bit sched,
                            output int c0);
    ev_t e;
    @(negedge clk);
    rx = 1'b0;
    c0 = cyc;
    if (sched) begin
      e.edge_n = cyc + 9 * p + p / 2 + SYNC + 3;
      e.d = b;
      e.good = stop;
      evq.push_back(e);
    end
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
    if (stop) rx = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int hits;
    #1;
    arst_n = 1'b0;
    idle(3);
    chk("init_busy", busy, 0);
    chk("init_rvalid", rvalid, 0);
    arst_n = 1'b1;
    idle(20);

    // 0x55 at 868 cycles/bit, consumer always ready
    rready = 1'b1;
    rv_rise = -1;
    send_frame(8'h55, 1'b1, 868, 1'b1, c0);
    idle(20);
    chk("t1_rdata", rdata, 8'h55);
    chk("t1_rvalid_dropped", rvalid, 0);
    chk_rng("t1_latency", rv_rise - c0, 8250, 8252);
    chk("t1_no_frame_err", fe_seen, 0);

    // bad stop, long break, then a good frame
    bit_period = 32'd64;
    send_frame(8'hA3, 1'b0, 64, 1'b1, c0);
    idle(2000);
    rx = 1'b1;
    idle(200);
    chk("t2_idle_after_break", busy, 0);
    send_frame(8'h3C, 1'b1, 64, 1'b1, c0);
    idle(20);
    chk("t2_frame_err_once", fe_seen, 1);
    chk("t2_rdata", rdata, 8'h3C);

    // false start: 300-cycle low pulse at period 868
    bit_period = 32'd868;
    @(negedge clk);
    rx = 1'b0;
    c0 = cyc;
    idle(300);
    rx = 1'b1;
    chk("t3_busy_during", busy, 1);
    while (busy && (cyc - c0) < 700) @(negedge clk);
    chk_rng("t3_busy_release", cyc - c0, 300, 439);
    chk("t3_no_rvalid", rvalid, 0);

    // overrun: two frames with consumer stalled
    bit_period = 32'd64;
    rready = 1'b0;
    send_frame(8'h12, 1'b1, 64, 1'b1, c0);
    send_frame(8'h34, 1'b1, 64, 1'b1, c0);
    idle(20);
    chk("t4_rdata_kept", rdata, 8'h12);
    chk("t4_rvalid_held", rvalid, 1);
    chk("t4_overrun_once", ov_seen, 1);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    @(negedge clk);
    chk("t4_rvalid_dropped", rvalid, 0);
    chk("t4_rdata_after", rdata, 8'h12);

    // reset in the middle of 0xF0 (during bit 4), then 0x81
    rready = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    idle(64 * 5);
    rx = 1'b1;
    idle(32);
    arst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdata", rdata, 0);
    idle(5);
    arst_n = 1'b1;
    idle(64 * 5);
    chk("t5_no_partial", rvalid, 0);
    chk("t5_idle", busy, 0);
    send_frame(8'h81, 1'b1, 64, 1'b1, c0);
    idle(20);
    chk("t5_rdata", rdata, 8'h81);

    // line held low across reset release must not start a frame
    @(negedge clk);
    arst_n = 1'b0;
    rx = 1'b0;
    idle(3);
    arst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) hits++;
    end
    chk("t6_no_start_low_line", hits, 0);
    rx = 1'b1;
    idle(20);

    // period below the clamp runs at 16 cycles/bit
    bit_period = 32'd5;
    send_frame(8'hC3, 1'b1, 16, 1'b1, c0);
    idle(20);
    chk("t7_rdata", rdata, 8'hC3);
    chk("events_drained", evq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
